ifu: RTL
========

Name: ifu

Overview:
- Instruction fetch unit: the producer side of the `inst` interface consumed by the decoder.
- Holds the architectural PC and fetches one 32-bit instruction per step over a read-only address/data handshake to instruction memory.
- Presents the instruction and its PC to decode/execute over a valid/ready handshake.
- Waits for the next-PC from writeback before issuing the next fetch. Non-pipelined, one instruction in flight.

Parameters:
- RESET_PC, 32'h80000000, PC loaded on reset.
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- araddr  out  ADDR_W  fetch address (current PC)
- arvalid  out  1  fetch request valid
- arready  in  1  memory accepts request
- rdata  in  32  fetched instruction word
- rresp  in  2  response code; 2'b00 = OKAY
- rvalid  in  1  response valid
- rready  out  1  IFU accepts response
- inst  out  32  instruction to decoder
- inst_pc  out  ADDR_W  PC of `inst`
- inst_valid  out  1  `inst`/`inst_pc` valid
- inst_ready  in  1  downstream accepts instruction
- npc_valid  in  1  single-cycle pulse: next PC available
- npc  in  ADDR_W  next PC from writeback
- fetch_err  out  1  sticky fetch fault flag

Behaviour:
- Reset (clk edge with rst==0):
  - pc=RESET_PC, state=REQ.
  - inst=0, inst_pc=0, fetch_err=0, npc_pend=0.
  - While rst==0, arvalid=0, rready=0 and inst_valid=0 regardless of state.
- States: REQ, RESP, ISSUE, WAIT_NPC. All outputs decode from state and registers, never from inputs.
- REQ:
  - arvalid=1, araddr=pc.
  - araddr is held stable until arready. On arvalid&&arready, go to RESP.
  - First arvalid appears in the first cycle after rst goes high.
- RESP:
  - rready=1.
  - On rvalid: inst<=rdata, inst_pc<=pc, go to ISSUE.
  - If rresp!=0: inst<=32'h00100073 (ebreak) and fetch_err<=1, so the decoder raises ebreak and simulation terminates.
- ISSUE:
  - inst_valid=1; inst and inst_pc are held stable until inst_ready.
  - On inst_ready: go to WAIT_NPC, or to REQ if npc_pend==1.
- WAIT_NPC:
  - On npc_valid: pc<=npc, go to REQ.
- npc_valid handling:
  - Accepted in ISSUE and WAIT_NPC only.
  - In ISSUE it is latched (pc<=npc, npc_pend<=1); npc_pend clears on entering REQ.
  - In REQ/RESP it is ignored.
  - A second pulse while npc_pend==1 overwrites pc (last wins).
- Misaligned npc (npc[1:0]!=0): pc<=npc unchanged; the next fetch returns ebreak without issuing a memory request (REQ goes straight to ISSUE), and fetch_err<=1.
- Latency: request to inst_valid is 1 cycle after the rvalid handshake. With zero-wait memory and immediate inst_ready/npc_valid, one instruction takes 4 cycles.
- Reset mid-transaction: FSM returns to REQ. Any outstanding response is dropped because rready=0 during reset; memory must tolerate the abandoned request.
- fetch_err clears only on reset.
- PC arithmetic is not done here; npc is supplied complete (pc+4, branch, jalr, trap vector, mepc).

Optional Feature:
- Macro: YSYX_23060059_IFU_PERF_EN.
- When defined, adds output ports:
  - perf_fetch_cnt (32): increments on each rvalid&&rready.
  - perf_stall_cnt (32): increments each cycle in REQ with !arready, or RESP with !rvalid.
- Both counters reset to 0 and wrap at 2^32.
- When undefined: no ports, no counter logic; all other behaviour is identical.

Decomposition:
- Package ifu_pkg holds:
  - state enum (REQ=2'd0, RESP=2'd1, ISSUE=2'd2, WAIT_NPC=2'd3);
  - INST_EBREAK=32'h00100073;
  - RESP_OKAY=2'b00;
  - default RESET_PC.
- Sub-module ifu_perf_cnt (two 32-bit counters with enables), instantiated only under YSYX_23060059_IFU_PERF_EN.

Test Plan:
- Reset release, memory arready=1, returns rdata=32'h00000413 OKAY next cycle, inst_ready=1 → araddr=32'h80000000, inst=32'h00000413, inst_pc=32'h80000000 in ISSUE; then npc_valid with npc=32'h80000004 → next araddr=32'h80000004.
- arready held low 3 cycles, then rvalid delayed 2 cycles → araddr stable throughout, arvalid stays high, no duplicate request; perf_stall_cnt=5 with PERF_EN.
- inst_ready low 4 cycles in ISSUE → inst/inst_pc unchanged, inst_valid stays 1; npc_valid pulse (npc=32'h80000100) during the stall → after inst_ready goes high, FSM goes directly to REQ with araddr=32'h80000100.
- rresp=2'b10 on fetch → inst=32'h00100073, fetch_err=1 and stays 1 across later OKAY fetches until rst=0.
- npc=32'h80000102 → no arvalid issued, inst=32'h00100073, inst_pc=32'h80000102, fetch_err=1.
- rst driven low while in RESP with rvalid=1 → next cycle rready=0, inst_valid=0, arvalid=0; after release, araddr=RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
// Contents: FSM state encoding, the ebreak instruction word that is
// substituted on a fetch fault, the OKAY response code and the default
// reset PC.
package ifu_pkg;

    typedef enum logic [1:0] {
        REQ      = 2'd0,
        RESP     = 2'd1,
        ISSUE    = 2'd2,
        WAIT_NPC = 2'd3
    } ifu_state_t;

    localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;
    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_perf_cnt.sv
// ifu_perf_cnt: two free-running 32-bit event counters for the fetch unit.
// Ports:
//   clk, rst           clock; synchronous active-low reset (counters -> 0)
//   fetch_en           count one completed fetch response this cycle
//   stall_en           count one memory stall cycle this cycle
//   perf_fetch_cnt     completed fetch count (wraps at 2^32)
//   perf_stall_cnt     stall cycle count (wraps at 2^32)
module ifu_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        stall_en,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_en) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall_en) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/ifu.sv
// ifu: non-pipelined instruction fetch unit, one instruction in flight.
// Holds the PC, fetches one 32-bit word over an address/data handshake,
// presents it to decode over valid/ready, then waits for the next PC.
// Ports:
//   clk, rst                       clock; synchronous active-low reset
//   araddr/arvalid/arready         fetch request to instruction memory
//   rdata/rresp/rvalid/rready      fetch response from instruction memory
//   inst/inst_pc/inst_valid/inst_ready   instruction to decoder
//   npc_valid/npc                  next PC pulse from writeback
//   fetch_err                      sticky fault flag (bus error or misaligned PC)
// Optional (macro YSYX_23060059_IFU_PERF_EN):
//   perf_fetch_cnt, perf_stall_cnt performance counters
//
// state    | meaning
// ---------+-----------------------------------------------------------
// REQ      | drive fetch request for pc (skipped if pc is misaligned)
// RESP     | accept memory response, capture instruction
// ISSUE    | present inst/inst_pc to decoder until accepted
// WAIT_NPC | wait for writeback to deliver the next PC
module ifu
    import ifu_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              npc_valid,
    input  logic [ADDR_W-1:0] npc,
    output logic              fetch_err
`ifdef YSYX_23060059_IFU_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    ifu_state_t        state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic              npc_pend;
    logic              misaligned;

    assign misaligned = |pc[1:0];

    // Handshake outputs are forced low while reset is asserted so that an
    // outstanding response is never accepted during reset.
    assign araddr     = pc;
    assign arvalid    = rst && (state == REQ) && !misaligned;
    assign rready     = rst && (state == RESP);
    assign inst_valid = rst && (state == ISSUE);

    always_comb begin
        state_nxt = state;
        case (state)
            REQ: begin
                // A misaligned PC never reaches memory; ebreak is issued instead.
                if (misaligned)   state_nxt = ISSUE;
                else if (arready) state_nxt = RESP;
            end
            RESP: begin
                if (rvalid) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (inst_ready) state_nxt = (npc_pend || npc_valid) ? REQ : WAIT_NPC;
            end
            WAIT_NPC: begin
                if (npc_valid) state_nxt = REQ;
            end
            default: state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= REQ;
            pc        <= RESET_PC;
            inst      <= '0;
            inst_pc   <= '0;
            fetch_err <= 1'b0;
            npc_pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                REQ: begin
                    if (misaligned) begin
                        inst      <= INST_EBREAK;
                        inst_pc   <= pc;
                        fetch_err <= 1'b1;
                    end
                end
                RESP: begin
                    if (rvalid) begin
                        inst_pc <= pc;
                        if (rresp != RESP_OKAY) begin
                            inst      <= INST_EBREAK;
                            fetch_err <= 1'b1;
                        end else begin
                            inst <= rdata;
                        end
                    end
                end
                ISSUE: begin
                    // Early next PC: last pulse wins, remembered until REQ.
                    if (npc_valid) begin
                        pc       <= npc;
                        npc_pend <= 1'b1;
                    end
                end
                WAIT_NPC: begin
                    if (npc_valid) pc <= npc;
                end
                default: ;
            endcase
            // Overrides the set above when ISSUE leaves for REQ in the same cycle.
            if (state_nxt == REQ) npc_pend <= 1'b0;
        end
    end

`ifdef YSYX_23060059_IFU_PERF_EN
    ifu_perf_cnt u_perf_cnt (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (rvalid && rready),
        .stall_en       (((state == REQ) && !arready) || ((state == RESP) && !rvalid)),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`endif

endmodule
